pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the RISC core's fetch stage, the successor to the combinational PC adder. It holds the architectural PC in a register, increments it by 2 or 4 bytes, and redirects it on a taken branch, jump or trap. It handshakes each fetch with instruction memory, checks redirect targets for misalignment, and keeps a count of accepted fetches.

---
 rtl/rv_pkg.sv | 17 +
 rtl/pc_incrementer.sv | 20 ++
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: default widths,
// vectors, sequencer states and instruction step sizes.
package rv_pkg;

   localparam int          XLEN_DEF         = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

   localparam int STEP_16 = 2;
   localparam int STEP_32 = 4;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/pc_incrementer.sv
// Link-address adder: pc plus the size of the current instruction.
// It wraps modulo 2^XLEN with no carry-out.
module pc_incrementer
   import rv_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int COMPRESSED = 0
)(
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_inst_is_16,
   output logic [XLEN-1:0] o_pc_plus
);

   logic [XLEN-1:0] w_step;

   // Without compressed support, inst_is_16 is ignored and the step is always 4.
   assign w_step    = ((COMPRESSED != 0) && i_inst_is_16) ? XLEN'(STEP_16) : XLEN'(STEP_32);
   assign o_pc_plus = i_pc + w_step;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer. It holds the PC and performs the
// fetch handshake, with trap/redirect priority, misalignment capture and a fetch counter.
module pc_sequencer
   import rv_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
   parameter int              COMPRESSED   = 0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap,
   input  logic            inst_is_16,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic            misalign,
   output logic [XLEN-1:0] bad_addr,
   output logic [XLEN-1:0] fetch_count
);

   seq_state_e      r_state;
   seq_state_e      w_next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_pc_plus;
   logic            r_misalign;
   logic            w_set_misalign;
   logic [XLEN-1:0] r_bad_addr;
   logic [XLEN-1:0] r_fetch_count;
   logic            w_accept;
   logic            w_misaligned;

   pc_incrementer #(
      .XLEN       (XLEN),
      .COMPRESSED (COMPRESSED)
   ) u_pc_incrementer (
      .i_pc         (r_pc),
      .i_inst_is_16 (inst_is_16),
      .o_pc_plus    (w_pc_plus)
   );

   assign fetch_valid  = (r_state == RUN);
   assign w_accept     = fetch_valid && fetch_ready;
   assign w_misaligned = (COMPRESSED != 0) ? redirect_target[0] : (|redirect_target[1:0]);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      w_next_state   = r_state;
      w_next_pc      = r_pc;
      w_set_misalign = 1'b0;
      case (r_state)
         BOOT: w_next_state = RUN;
         RUN: begin
            // Trap and redirect win over stall and over a pending, unaccepted request.
            if (trap) begin
               w_next_pc = TRAP_VECTOR;
            end else if (redirect_valid && w_misaligned) begin
               w_next_pc      = TRAP_VECTOR;
               w_set_misalign = 1'b1;
            end else if (redirect_valid) begin
               w_next_pc = redirect_target;
            end else if (!stall && w_accept) begin
               w_next_pc = w_pc_plus;
            end
         end
         default: w_next_state = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
      if (!rst) r_state <= BOOT;
      else      r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_VECTOR;
         r_misalign    <= 1'b0;
         r_bad_addr    <= '0;
         r_fetch_count <= '0;
      end else begin
         r_pc       <= w_next_pc;
         r_misalign <= w_set_misalign;
         if (w_set_misalign) r_bad_addr <= redirect_target;
         // The old address was accepted even if a redirect lands on this edge.
         if (w_accept) r_fetch_count <= r_fetch_count + 1'b1;
      end
   end

   assign pc          = r_pc;
   assign pc_plus     = w_pc_plus;
   assign misalign    = r_misalign;
   assign bad_addr    = r_bad_addr;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Two instances (COMPRESSED=0 and 1)
// share stimulus, and table rows push expected results through a scoreboard queue.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap;
   logic        inst_is_16;
   logic        fetch_ready;

   logic        fv0, fv1, mis0, mis1;
   logic [31:0] pc0, pc1, pp0, pp1, bad0, bad1, cnt0, cnt1;

   pc_sequencer #(.XLEN(32), .COMPRESSED(0)) u_dut0 (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap            (trap),
      .inst_is_16      (inst_is_16),
      .fetch_valid     (fv0),
      .fetch_ready     (fetch_ready),
      .pc              (pc0),
      .pc_plus         (pp0),
      .misalign        (mis0),
      .bad_addr        (bad0),
      .fetch_count     (cnt0)
   );

   pc_sequencer #(.XLEN(32), .COMPRESSED(1)) u_dut1 (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap            (trap),
      .inst_is_16      (inst_is_16),
      .fetch_valid     (fv1),
      .fetch_ready     (fetch_ready),
      .pc              (pc1),
      .pc_plus         (pp1),
      .misalign        (mis1),
      .bad_addr        (bad1),
      .fetch_count     (cnt1)
   );

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] tgt;
      logic        trap;
      logic        i16;
      logic        ready;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        mis0;
      logic        mis1;
      logic [31:0] bad0;
      logic [31:0] bad1;
   } vec_t;

   typedef struct {
      logic [31:0] pc0, pc1, pp0, pp1, bad0, bad1, cnt;
      logic        mis0, mis1;
   } exp_t;

   localparam int NV = 19;
   vec_t vec [NV];
   exp_t exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_both_reset(input string tag);
      check({tag, " pc0"},   pc0,         32'h0);
      check({tag, " pc1"},   pc1,         32'h0);
      check({tag, " fv0"},   32'(fv0),    32'h0);
      check({tag, " fv1"},   32'(fv1),    32'h0);
      check({tag, " cnt0"},  cnt0,        32'h0);
      check({tag, " cnt1"},  cnt1,        32'h0);
      check({tag, " mis0"},  32'(mis0),   32'h0);
      check({tag, " mis1"},  32'(mis1),   32'h0);
      check({tag, " bad0"},  bad0,        32'h0);
      check({tag, " bad1"},  bad1,        32'h0);
   endtask

   initial begin
      exp_t e;
      int   exp_cnt;

      //         stall rv   tgt           trap i16  rdy  pc0           pc1           m0   m1   bad0          bad1
      vec[0]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h4,        32'h4,        1'b0,1'b0,32'h0,        32'h0};
      vec[1]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h8,        32'h8,        1'b0,1'b0,32'h0,        32'h0};
      vec[2]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h8,        32'h8,        1'b0,1'b0,32'h0,        32'h0};
      vec[3]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h8,        32'h8,        1'b0,1'b0,32'h0,        32'h0};
      vec[4]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h8,        32'h8,        1'b0,1'b0,32'h0,        32'h0};
      vec[5]  = '{1'b1,1'b1,32'h200,      1'b0,1'b0,1'b1,32'h200,      32'h200,      1'b0,1'b0,32'h0,        32'h0};
      vec[6]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h200,      32'h200,      1'b0,1'b0,32'h0,        32'h0};
      vec[7]  = '{1'b0,1'b1,32'h202,      1'b0,1'b0,1'b1,32'h100,      32'h202,      1'b1,1'b0,32'h202,      32'h0};
      vec[8]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h104,      32'h206,      1'b0,1'b0,32'h202,      32'h0};
      vec[9]  = '{1'b0,1'b1,32'h300,      1'b1,1'b0,1'b1,32'h100,      32'h100,      1'b0,1'b0,32'h202,      32'h0};
      vec[10] = '{1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0,1'b0,32'h202,      32'h0};
      vec[11] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b0,32'h202,      32'h0};
      vec[12] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h4,        32'h2,        1'b0,1'b0,32'h202,      32'h0};
      vec[13] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h8,        32'h6,        1'b0,1'b0,32'h202,      32'h0};
      vec[14] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hC,        32'h8,        1'b0,1'b0,32'h202,      32'h0};
      vec[15] = '{1'b0,1'b1,32'h201,      1'b0,1'b0,1'b1,32'h100,      32'h100,      1'b1,1'b1,32'h201,      32'h201};
      vec[16] = '{1'b0,1'b1,32'h203,      1'b0,1'b0,1'b0,32'h100,      32'h100,      1'b1,1'b1,32'h203,      32'h203};
      vec[17] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h100,      32'h100,      1'b0,1'b0,32'h203,      32'h203};
      vec[18] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h100,      32'h100,      1'b0,1'b0,32'h203,      32'h203};

      rst             = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      trap            = 1'b0;
      inst_is_16      = 1'b0;
      fetch_ready     = 1'b1;
      exp_cnt         = 0;

      #2;
      check_both_reset("reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("boot fv0", 32'(fv0), 32'h0);
      check("boot pc0", pc0,      32'h0);
      @(posedge clk); #1;
      check("run0 fv0",  32'(fv0), 32'h1);
      check("run0 fv1",  32'(fv1), 32'h1);
      check("run0 pc0",  pc0,      32'h0);
      check("run0 cnt0", cnt0,     32'h0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         stall           = vec[i].stall;
         redirect_valid  = vec[i].rv;
         redirect_target = vec[i].tgt;
         trap            = vec[i].trap;
         inst_is_16      = vec[i].i16;
         fetch_ready     = vec[i].ready;
         if (vec[i].ready) exp_cnt++;
         e.pc0  = vec[i].pc0;
         e.pc1  = vec[i].pc1;
         e.pp0  = vec[i].pc0 + 32'd4;
         e.pp1  = vec[i].pc1 + (vec[i].i16 ? 32'd2 : 32'd4);
         e.bad0 = vec[i].bad0;
         e.bad1 = vec[i].bad1;
         e.mis0 = vec[i].mis0;
         e.mis1 = vec[i].mis1;
         e.cnt  = 32'(exp_cnt);
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check($sformatf("row%0d pc0", i),  pc0,        e.pc0);
         check($sformatf("row%0d pc1", i),  pc1,        e.pc1);
         check($sformatf("row%0d pp0", i),  pp0,        e.pp0);
         check($sformatf("row%0d pp1", i),  pp1,        e.pp1);
         check($sformatf("row%0d mis0", i), 32'(mis0),  32'(e.mis0));
         check($sformatf("row%0d mis1", i), 32'(mis1),  32'(e.mis1));
         check($sformatf("row%0d bad0", i), bad0,       e.bad0);
         check($sformatf("row%0d bad1", i), bad1,       e.bad1);
         check($sformatf("row%0d cnt0", i), cnt0,       e.cnt);
         check($sformatf("row%0d cnt1", i), cnt1,       e.cnt);
         check($sformatf("row%0d fv0", i),  32'(fv0),   32'h1);
         check($sformatf("row%0d fv1", i),  32'(fv1),   32'h1);
      end

      // Mid-run asynchronous reset: values must clear before any clock edge.
      @(negedge clk);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      trap           = 1'b0;
      inst_is_16     = 1'b0;
      fetch_ready    = 1'b1;
      rst            = 1'b0;
      #1;
      check_both_reset("async rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reboot fv0", 32'(fv0), 32'h0);
      @(posedge clk); #1;
      check("reboot edge1 fv0",  32'(fv0), 32'h1);
      check("reboot edge1 pc0",  pc0,      32'h0);
      check("reboot edge1 cnt0", cnt0,     32'h0);
      @(posedge clk); #1;
      check("reboot edge2 pc0",  pc0,      32'h4);
      check("reboot edge2 cnt1", cnt1,     32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
